// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI encodings, FSM state types and burst legality check
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full 32-bit beats are supported by the word-wide RAM.
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    // A burst is refused (SLVERR, no memory effect) when its beats are not
    // word sized, its type is reserved, or a WRAP length is not a power of two.
    function automatic logic burst_is_err(input logic [2:0] size,
                                          input logic [3:0] len,
                                          input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        return (size != SIZE_WORD) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !wrap_len_ok);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - next beat address for FIXED/INCR/WRAP word bursts
//
// Ports:
//   addr_i      current beat byte address
//   len_i       burst length minus one
//   burst_i     burst type
//   next_addr_o address of the following beat
module axi_burst_addr
    import axi_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [3:0]  len_i,
    input  logic [1:0]  burst_i,
    output logic [31:0] next_addr_o
);

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;

    always_comb begin
        incr_addr = addr_i + 32'd4;
        // (len+1)*4 - 1; a contiguous mask only for legal WRAP lengths,
        // illegal ones are answered with SLVERR so the address is irrelevant.
        wrap_mask = {26'd0, len_i, 2'b11};
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_ram_slave.sv
// rtl/axi_ram_slave.sv - AXI3 slave exposing a 32-bit word RAM with independent read/write FSMs
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   ar* / arready         read address channel (lock/cache/prot ignored)
//   r* / rready           read data channel
//   aw* / awready         write address channel (lock/cache/prot ignored)
//   w* / wready           write data channel (wid ignored)
//   b* / bready           write response channel
module axi_ram_slave
    import axi_pkg::*;
#(
    parameter int MEM_AW    = 12,
    parameter int INIT_ZERO = 1
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          MEM_WORDS = 1 << MEM_AW;
    localparam logic [31:0] MEM_INIT  = (INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx;

    // Contents live outside the reset domain: reset never touches memory.
    logic [31:0] mem_q [MEM_WORDS] = '{default: MEM_INIT};

    logic unused_inputs;
    assign unused_inputs = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

    // ---------------------------------------------------------------- read
    r_state_e    r_state_q, r_state_d;
    logic [3:0]  r_id_q;
    logic [31:0] r_addr_q;
    logic [3:0]  r_len_q;
    logic [3:0]  r_beat_q;
    logic [1:0]  r_burst_q;
    logic        r_err_q;
    logic [31:0] r_data_q;
    logic [31:0] r_next_addr;
    logic        ar_hs;
    logic        r_hs;
    logic        r_final;

    assign ar_hs   = arvalid && arready;
    assign r_hs    = rvalid && rready;
    assign r_final = (r_state_q == R_BURST) && (r_beat_q == r_len_q);

    axi_burst_addr u_rd_addr (
        .addr_i      (r_addr_q),
        .len_i       (r_len_q),
        .burst_i     (r_burst_q),
        .next_addr_o (r_next_addr)
    );

    // r_data_q only loads on acceptance or on a non-final handshake, which
    // keeps the presented beat frozen while the master stalls.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_beat_q  <= '0;
            r_burst_q <= '0;
            r_err_q   <= 1'b0;
            r_data_q  <= '0;
        end else begin
            r_state_q <= r_state_d;
            if (ar_hs) begin
                r_id_q    <= arid;
                r_addr_q  <= araddr;
                r_len_q   <= arlen;
                r_beat_q  <= '0;
                r_burst_q <= arburst;
                r_err_q   <= burst_is_err(arsize, arlen, arburst);
                r_data_q  <= mem_q[araddr[MEM_AW+1:2]];
            end else if (r_hs && !r_final) begin
                r_addr_q <= r_next_addr;
                r_beat_q <= r_beat_q + 4'd1;
                r_data_q <= mem_q[r_next_addr[MEM_AW+1:2]];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_BURST;
            R_BURST: if (r_hs && r_final) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready = (r_state_q == R_IDLE) && !areset;
        rvalid  = (r_state_q == R_BURST);
        rlast   = r_final;
        rid     = r_id_q;
        rresp   = r_err_q ? RESP_SLVERR : RESP_OKAY;
        rdata   = r_err_q ? 32'h0 : r_data_q;
    end

    // --------------------------------------------------------------- write
    w_state_e    w_state_q, w_state_d;
    logic [3:0]  w_id_q;
    logic [31:0] w_addr_q;
    logic [3:0]  w_len_q;
    logic [3:0]  w_beat_q;
    logic [1:0]  w_burst_q;
    logic        w_err_q;
    logic        w_last_err_q;
    logic [31:0] w_next_addr;
    logic        aw_hs;
    logic        w_hs;
    logic        w_final;

    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign w_final = (w_beat_q == w_len_q);

    axi_burst_addr u_wr_addr (
        .addr_i      (w_addr_q),
        .len_i       (w_len_q),
        .burst_i     (w_burst_q),
        .next_addr_o (w_next_addr)
    );

    // Length is taken from awlen alone; wlast is only cross-checked, so a
    // misplaced wlast is reported but never shortens or extends the burst.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q    <= W_IDLE;
            w_id_q       <= '0;
            w_addr_q     <= '0;
            w_len_q      <= '0;
            w_beat_q     <= '0;
            w_burst_q    <= '0;
            w_err_q      <= 1'b0;
            w_last_err_q <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            if (aw_hs) begin
                w_id_q       <= awid;
                w_addr_q     <= awaddr;
                w_len_q      <= awlen;
                w_beat_q     <= '0;
                w_burst_q    <= awburst;
                w_err_q      <= burst_is_err(awsize, awlen, awburst);
                w_last_err_q <= 1'b0;
            end else if (w_hs) begin
                if (wlast != w_final) begin
                    w_last_err_q <= 1'b1;
                end
                if (!w_final) begin
                    w_beat_q <= w_beat_q + 4'd1;
                    w_addr_q <= w_next_addr;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_hs && !w_err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_q[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_d = W_RESP;
            W_RESP:  if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        awready = (w_state_q == W_IDLE) && !areset;
        wready  = (w_state_q == W_DATA) && !areset;
        bvalid  = (w_state_q == W_RESP);
        bid     = w_id_q;
        bresp   = (w_err_q || w_last_err_q) ? RESP_SLVERR : RESP_OKAY;
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb/tb_axi_ram_slave.sv - self-checking bench for axi_ram_slave
module tb_axi_ram_slave;

    logic        aclk;
    logic        areset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    axi_ram_slave dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference memory: 4096 words, starts cleared
    logic [31:0] mdl [4096];

    logic [31:0] wb_data [16];
    logic [3:0]  wb_strb [16];
    bit          wr_ok;
    int          wr_beats;
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;

    logic [31:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    bit          rd_last [$];
    logic [3:0]  rd_rid;
    bit          rd_ok;
    bit          rd_first_valid;
    int          rd_gaps;
    int          rd_cycles;
    int          stab_err;
    bit          rr_pat [$];

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] raddr;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic [3:0]  strb;
        logic [31:0] pre;
        logic [31:0] wdat;
        logic [1:0]  exp_bresp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit mdl_err(input logic [2:0] size, input logic [3:0] len, input logic [1:0] burst);
        return (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    // beat i address straight from the burst rules: wrap window is (len+1)*4 bytes
    function automatic logic [31:0] mdl_addr(input logic [31:0] addr, input logic [3:0] len, input logic [1:0] burst, input int i);
        logic [31:0] nbytes;
        logic [31:0] base;
        nbytes = (32'(len) + 32'd1) * 32'd4;
        base   = addr - (addr % nbytes);
        case (burst)
            2'b00:   return addr;
            2'b10:   return base + ((addr - base + 32'(4 * i)) % nbytes);
            default: return addr + 32'(4 * i);
        endcase
    endfunction

    function automatic int mdl_idx(input logic [31:0] a);
        return int'((a >> 2) % 32'd4096);
    endfunction

    task automatic mdl_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst);
        int k;
        if (!mdl_err(size, len, burst)) begin
            for (int i = 0; i <= int'(len); i++) begin
                k = mdl_idx(mdl_addr(addr, len, burst, i));
                for (int b = 0; b < 4; b++)
                    if (wb_strb[i][b]) mdl[k][8*b +: 8] = wb_data[i][8*b +: 8];
            end
        end
    endtask

    // all bus tasks start and end on a falling edge
    task automatic bus_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input int last_at);
        int t;
        wr_ok = 1'b1;
        wr_beats = 0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        t = 0;
        while (!awready && t < 50) begin @(negedge aclk); t++; end
        if (!awready) wr_ok = 1'b0;
        @(negedge aclk);
        awvalid = 1'b0;
        for (int b = 0; b <= int'(len) && wr_ok; b++) begin
            wid = id; wdata = wb_data[b]; wstrb = wb_strb[b]; wvalid = 1'b1;
            wlast = (last_at < 0) ? (b == int'(len)) : (b == last_at);
            t = 0;
            while (!wready && t < 50) begin @(negedge aclk); t++; end
            if (!wready) wr_ok = 1'b0;
            else wr_beats++;
            @(negedge aclk);
        end
        wvalid = 1'b0;
        wlast = 1'b0;
        bready = 1'b1;
        t = 0;
        while (!bvalid && t < 50) begin @(negedge aclk); t++; end
        if (!bvalid) wr_ok = 1'b0;
        wr_bresp = bresp;
        wr_bid = bid;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // mode 0: rready always 1, mode 1: random rready, mode 2: rr_pat then 1
    task automatic bus_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int mode);
        int t;
        int pi;
        bit done;
        bit stalled;
        logic [31:0] s_data;
        logic [1:0]  s_resp;
        logic        s_last;
        logic [3:0]  s_id;
        rd_data.delete(); rd_resp.delete(); rd_last.delete();
        rd_ok = 1'b1; rd_gaps = 0; rd_cycles = 0; stab_err = 0; rd_rid = 4'hx;
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        if (!arready) rd_ok = 1'b0;
        @(negedge aclk);
        arvalid = 1'b0;
        rd_first_valid = rvalid;
        done = 1'b0; stalled = 1'b0; pi = 0;
        s_data = '0; s_resp = '0; s_last = 1'b0; s_id = '0;
        while (!done && rd_cycles < 300) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = 1'($urandom_range(0, 1));
                default: rready = (pi < rr_pat.size()) ? rr_pat[pi] : 1'b1;
            endcase
            pi++;
            if (rvalid) begin
                if (stalled && (rdata !== s_data || rresp !== s_resp || rlast !== s_last || rid !== s_id))
                    stab_err++;
                if (rready) begin
                    rd_data.push_back(rdata);
                    rd_resp.push_back(rresp);
                    rd_last.push_back(rlast);
                    rd_rid = rid;
                    done = rlast;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    s_data = rdata; s_resp = rresp; s_last = rlast; s_id = rid;
                end
            end else begin
                rd_gaps++;
            end
            @(negedge aclk);
            rd_cycles++;
        end
        rready = 1'b0;
        if (!done) rd_ok = 1'b0;
    endtask

    task automatic check_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        bit e;
        logic [31:0] exp_d;
        e = mdl_err(size, len, burst);
        check("rd_done", 64'(rd_ok), 64'(1));
        check("rd_beats", 64'(rd_data.size()), 64'(int'(len) + 1));
        check("rd_rid", 64'(rd_rid), 64'(id));
        check("rd_stable", 64'(stab_err), 64'(0));
        for (int i = 0; i < rd_data.size(); i++) begin
            exp_d = e ? 32'h0 : mdl[mdl_idx(mdl_addr(addr, len, burst, i))];
            check("rd_data", 64'(rd_data[i]), 64'(exp_d));
            check("rd_resp", 64'(rd_resp[i]), e ? 64'd2 : 64'd0);
            check("rd_last", 64'(rd_last[i]), 64'(i == int'(len)));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [3:0]  id;
        int t;

        for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
        areset = 1'b1;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        rready = 1'b0; bready = 1'b0;

        vecs[0] = '{32'h200,  32'h200, 3'd2, 2'b01, 4'b0101, 32'h11223344, 32'hAABBCCDD, 2'd0, 32'h11BB33DD};
        vecs[1] = '{32'h204,  32'h204, 3'd2, 2'b01, 4'b1111, 32'h11223344, 32'hAABBCCDD, 2'd0, 32'hAABBCCDD};
        vecs[2] = '{32'h208,  32'h208, 3'd2, 2'b00, 4'b0000, 32'h11223344, 32'hAABBCCDD, 2'd0, 32'h11223344};
        vecs[3] = '{32'h20C,  32'h20C, 3'd2, 2'b01, 4'b1010, 32'h11223344, 32'hAABBCCDD, 2'd0, 32'hAA22CC44};
        vecs[4] = '{32'h210,  32'h210, 3'd1, 2'b01, 4'b1111, 32'h11223344, 32'hAABBCCDD, 2'd2, 32'h11223344};
        vecs[5] = '{32'h214,  32'h214, 3'd2, 2'b11, 4'b1111, 32'h11223344, 32'hAABBCCDD, 2'd2, 32'h11223344};
        vecs[6] = '{32'h4218, 32'h218, 3'd2, 2'b01, 4'b1111, 32'h11223344, 32'hAABBCCDD, 2'd0, 32'hAABBCCDD};
        vecs[7] = '{32'h21C,  32'h21C, 3'd2, 2'b10, 4'b1111, 32'h11223344, 32'hAABBCCDD, 2'd2, 32'h11223344};

        // reset state
        repeat (3) @(negedge aclk);
        check("rst_outputs", 64'({rvalid, rlast, wready, bvalid, rid, bid, rresp, bresp, rdata}), 64'(0));
        areset = 1'b0;
        @(negedge aclk);
        check("rst_arready", 64'(arready), 64'(1));
        check("rst_awready", 64'(awready), 64'(1));

        // INCR read of A..D at 0x100
        wb_data[0] = 32'hAAAA_0001; wb_data[1] = 32'hBBBB_0002; wb_data[2] = 32'hCCCC_0003; wb_data[3] = 32'hDDDD_0004;
        for (int i = 0; i < 4; i++) wb_strb[i] = 4'hF;
        bus_write(4'd1, 32'h100, 4'd3, 3'd2, 2'b01, -1);
        mdl_write(32'h100, 4'd3, 3'd2, 2'b01);
        check("incr_wr_done", 64'(wr_ok), 64'(1));
        check("incr_bresp", 64'(wr_bresp), 64'(0));
        check("incr_bid", 64'(wr_bid), 64'(1));
        bus_read(4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 0);
        check_read(4'd5, 32'h100, 4'd3, 3'd2, 2'b01);
        check("incr_first_latency", 64'(rd_first_valid), 64'(1));
        check("incr_back_to_back", 64'(rd_cycles), 64'(4));
        check("incr_gaps", 64'(rd_gaps), 64'(0));
        check("incr_beat0", 64'(rd_data.size() > 0 ? rd_data[0] : 32'hx), 64'(32'hAAAA_0001));
        check("incr_beat3", 64'(rd_data.size() > 3 ? rd_data[3] : 32'hx), 64'(32'hDDDD_0004));

        // WRAP write at 0x38 then linear readback of 0x30..0x3C
        for (int i = 0; i < 4; i++) wb_data[i] = 32'(i + 1);
        bus_write(4'd2, 32'h38, 4'd3, 3'd2, 2'b10, -1);
        mdl_write(32'h38, 4'd3, 3'd2, 2'b10);
        check("wrap_bresp", 64'(wr_bresp), 64'(0));
        bus_read(4'd3, 32'h30, 4'd3, 3'd2, 2'b01, 0);
        check_read(4'd3, 32'h30, 4'd3, 3'd2, 2'b01);
        check("wrap_words", 64'(rd_data.size() == 4 ? {rd_data[0][7:0], rd_data[1][7:0], rd_data[2][7:0], rd_data[3][7:0]} : 32'hx),
              64'(32'h03040102));

        // backpressure 1,0,0,1 on a two-beat read
        rr_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus_read(4'd7, 32'h100, 4'd1, 3'd2, 2'b01, 2);
        check("bp_handshakes", 64'(rd_data.size()), 64'(2));
        check("bp_cycles", 64'(rd_cycles), 64'(4));
        check("bp_stable", 64'(stab_err), 64'(0));
        check("bp_beat1", 64'(rd_data.size() > 1 ? rd_data[1] : 32'hx), 64'(32'hBBBB_0002));

        // error cases
        bus_read(4'd8, 32'h100, 4'd1, 3'b001, 2'b01, 0);
        check_read(4'd8, 32'h100, 4'd1, 3'b001, 2'b01);
        check("err_rdata0", 64'(rd_data.size() > 0 ? rd_data[0] : 32'hx), 64'(0));
        bus_write(4'd9, 32'h300, 4'd2, 3'd2, 2'b01, 1);
        check("wlast_err_done", 64'(wr_ok), 64'(1));
        check("wlast_err_beats", 64'(wr_beats), 64'(3));
        check("wlast_err_bresp", 64'(wr_bresp), 64'(2));
        check("wlast_err_bid", 64'(wr_bid), 64'(9));

        // single-beat strobe / error / alias vectors
        for (int v = 0; v < 8; v++) begin
            wb_data[0] = vecs[v].pre; wb_strb[0] = 4'hF;
            bus_write(4'd0, vecs[v].raddr, 4'd0, 3'd2, 2'b01, -1);
            mdl_write(vecs[v].raddr, 4'd0, 3'd2, 2'b01);
            wb_data[0] = vecs[v].wdat; wb_strb[0] = vecs[v].strb;
            bus_write(4'(v), vecs[v].waddr, 4'd0, vecs[v].size, vecs[v].burst, -1);
            mdl_write(vecs[v].waddr, 4'd0, vecs[v].size, vecs[v].burst);
            check($sformatf("vec%0d_bresp", v), 64'(wr_bresp), 64'(vecs[v].exp_bresp));
            bus_read(4'd0, vecs[v].raddr, 4'd0, 3'd2, 2'b01, 0);
            check($sformatf("vec%0d_rdata", v), 64'(rd_data.size() > 0 ? rd_data[0] : 32'hx), 64'(vecs[v].exp_rdata));
        end

        // reset in the middle of an 8-beat read
        for (int i = 0; i < 8; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'hF; end
        bus_write(4'd4, 32'h400, 4'd7, 3'd2, 2'b01, -1);
        mdl_write(32'h400, 4'd7, 3'd2, 2'b01);
        arid = 4'd6; araddr = 32'h400; arlen = 4'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 50) begin @(negedge aclk); t++; end
        @(negedge aclk);
        arvalid = 1'b0;
        rready = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        check("rst_mid_beat2", 64'(rdata), 64'(mdl[mdl_idx(32'h408)]));
        areset = 1'b1;
        @(negedge aclk);
        check("rst_mid_rvalid", 64'(rvalid), 64'(0));
        rready = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        check("rst_mid_arready", 64'(arready), 64'(1));
        bus_read(4'd6, 32'h400, 4'd7, 3'd2, 2'b01, 0);
        check_read(4'd6, 32'h400, 4'd7, 3'd2, 2'b01);

        // randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            a     = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 63)) << 2);
            len   = 4'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            id    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wb_data[i] = $urandom; wb_strb[i] = 4'($urandom_range(0, 15)); end
                bus_write(id, a, len, size, burst, -1);
                mdl_write(a, len, size, burst);
                check("rnd_wr_done", 64'(wr_ok), 64'(1));
                check("rnd_bresp", 64'(wr_bresp), mdl_err(size, len, burst) ? 64'd2 : 64'd0);
                check("rnd_bid", 64'(wr_bid), 64'(id));
            end else begin
                bus_read(id, a, len, size, burst, 1);
                check_read(id, a, len, size, burst);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_ram_slave.md
AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

Interface
REQ-001 Parameter MEM_AW, default 12, word-address width; memory holds 2^MEM_AW 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1, memory cleared to zero at elaboration when 1.
REQ-003 aclk  input  1  sole clock; all logic on rising edge.
REQ-004 areset  input  1  synchronous, active-high reset.
REQ-005 arid/araddr/arlen/arsize/arburst  input  4/32/4/3/2  AR channel payload.
REQ-006 arlock/arcache/arprot  input  2/4/3  accepted and ignored.
REQ-007 arvalid input 1, arready output 1  AR handshake.
REQ-008 rid/rdata/rresp/rlast/rvalid  output  4/32/2/1/1  R channel; rready input 1.
REQ-009 awid/awaddr/awlen/awsize/awburst  input  4/32/4/3/2  AW payload; awlock/awcache/awprot input 2/4/3 ignored.
REQ-010 awvalid input 1, awready output 1  AW handshake.
REQ-011 wid/wdata/wstrb/wlast/wvalid  input  4/32/4/1/1  W channel; wready output 1.
REQ-012 bid/bresp/bvalid  output  4/2/1  B channel; bready input 1.

Function
REQ-013 Word index SHALL be addr[MEM_AW+1:2]; higher address bits ignored (memory aliases).
REQ-014 Read and write paths SHALL be independent FSMs over a dual-port memory; same-cycle read and write of one word returns the old data.
REQ-015 Read FSM SHALL have states R_IDLE, R_BURST; arready=1 only in R_IDLE.
REQ-016 On arvalid&arready, the block SHALL latch id/addr/len/burst, issue the first memory read, and enter R_BURST.
REQ-017 rvalid SHALL rise exactly one cycle after AR acceptance; each following beat one cycle after the prior rvalid&rready.
REQ-018 rdata/rresp/rlast/rid SHALL hold stable while rvalid&!rready.
REQ-019 rlast SHALL be 1 on beat number arlen (0-based); rvalid&rready&rlast returns to R_IDLE, next AR acceptable that same cycle+1.
REQ-020 Address sequencing: FIXED constant; INCR +4 per beat; WRAP +4 wrapping at (len+1)*4-aligned boundary; reserved burst 2'b11 treated as INCR with SLVERR.
REQ-021 Burst SHALL get rresp/bresp SLVERR (2'b10), rdata 0, no memory write, if size≠3'b010, burst=2'b11, or WRAP with len not in {1,3,7,15}; otherwise OKAY (2'b00).
REQ-022 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP; awready=1 only in W_IDLE, wready=1 only in W_DATA.
REQ-023 Each wvalid&wready beat SHALL write byte lanes where wstrb bit set; wid ignored.
REQ-024 W_DATA SHALL exit to W_RESP on the beat with beat count==awlen; wlast mismatch (early or missing) SHALL force SLVERR, remaining beats still drained to count awlen.
REQ-025 W_RESP SHALL hold bvalid=1 with bid=latched awid until bready, then W_IDLE.
REQ-026 Beat counters SHALL be 4 bits, never wrapping past len.

Reset
REQ-027 While areset=1: both FSMs to IDLE; arready, awready =1 the cycle after reset deasserts; rvalid, rlast, wready, bvalid =0; rid, bid, rresp, bresp, rdata =0.
REQ-028 Reset mid-burst SHALL abandon the transaction without a response; memory contents SHALL NOT be altered by reset.

Structure
REQ-029 Shared package axi_pkg SHALL hold burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR), and read/write state enums.
REQ-030 One sub-module axi_burst_addr SHALL compute next address from addr/len/burst, instanced once per path.

Verification
REQ-031 INCR read: araddr=0x100, arlen=3, mem[0x40..0x43]=A,B,C,D, rready=1 -> 4 beats A..D back-to-back, rlast on 4th, rid echoed, rresp=0.
REQ-032 WRAP write then read: awaddr=0x38, awlen=3, data 1..4 -> words 0x38,0x3C,0x30,0x34 hold 1,2,3,4; bresp=0.
REQ-033 Backpressure: rready toggled 1,0,0,1 during arlen=1 read -> rdata stable across stall, exactly 2 handshakes.
REQ-034 Strobes: write 0xAABBCCDD wstrb=4'b0101 over 0x11223344 -> readback 0x11BB33DD.
REQ-035 Error: arsize=3'b001 arlen=1 -> 2 beats rresp=2'b10 rdata=0; awlen=2 with wlast on beat 1 -> bresp=2'b10 after 3 beats.
REQ-036 Reset asserted during beat 2 of arlen=7 read -> rvalid=0 next cycle, arready=1 after release, memory unchanged.
